// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: command width, opcode constants,
// FSM state encoding and a small opcode-legality helper.
package alu_pkg;

  localparam int unsigned CmdW = 4;

  typedef logic [CmdW-1:0] cmd_t;

  localparam cmd_t CmdAdd  = 4'd0;
  localparam cmd_t CmdSub  = 4'd1;
  localparam cmd_t CmdXor  = 4'd2;
  localparam cmd_t CmdSlt  = 4'd3;
  localparam cmd_t CmdAnd  = 4'd4;
  localparam cmd_t CmdNand = 4'd5;
  localparam cmd_t CmdNor  = 4'd6;
  localparam cmd_t CmdOr   = 4'd7;
  localparam cmd_t CmdMul  = 4'd8;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDone
  } state_e;

  // Opcodes 9..15 are reserved.
  function automatic logic is_illegal(input cmd_t cmd);
    return cmd > CmdMul;
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry and signed overflow.
// Shared by ADD, SUB, SLT and the multiply accumulate step.
//   a_i, b_i    : operands
//   sub_i       : 1 computes a_i + ~b_i + 1, 0 computes a_i + b_i
//   sum_o       : WIDTH-bit sum
//   carry_o     : carry out of the MSB (1 = no borrow when subtracting)
//   overflow_o  : signed result does not fit in WIDTH bits
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff      = sub_i ? ~b_i : b_i;
    full       = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
    sum_o      = full[WIDTH-1:0];
    carry_o    = full[WIDTH];
    // Same-sign inputs producing an opposite-sign sum.
    overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle
// logic/arithmetic ops complete with latency 1; MUL runs a WIDTH-cycle
// shift-add sequence that reuses the shared adder.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake for operandA, operandB, command
//   out_valid / out_ready : output handshake for result and flags
//   result                : registered result
//   carryout, zero,
//   overflow, illegal     : registered flags
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [CmdW-1:0]  command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  // Multiply state: acc holds the upper product half, mplier shifts the
  // multiplier out while the lower product half shifts in.
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic accept;
  logic mul_last;

  // Shared adder
  logic [WIDTH-1:0] as_a, as_b, as_sum;
  logic             as_sub, as_carry, as_ovf;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf;

  always_comb begin
    if (state_q == StMul) begin
      as_a   = acc_q;
      as_b   = mplier_q[0] ? mcand_q : '0;
      as_sub = 1'b0;
    end else begin
      as_a   = operandA;
      as_b   = operandB;
      as_sub = (command != CmdAdd);
    end
  end

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a_i       (as_a),
    .b_i       (as_b),
    .sub_i     (as_sub),
    .sum_o     (as_sum),
    .carry_o   (as_carry),
    .overflow_o(as_ovf)
  );

  // Single-cycle operation result, valid only when the adder sees live operands.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (command)
      CmdAdd, CmdSub: begin
        alu_res   = as_sum;
        alu_carry = as_carry;
        alu_ovf   = as_ovf;
      end
      CmdSlt:  alu_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      CmdXor:  alu_res = operandA ^ operandB;
      CmdAnd:  alu_res = operandA & operandB;
      CmdNand: alu_res = ~(operandA & operandB);
      CmdNor:  alu_res = ~(operandA | operandB);
      CmdOr:   alu_res = operandA | operandB;
      default: alu_res = '0;
    endcase
  end

  // FSM output process
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIdle:  in_ready = 1'b1;
        StDone:  in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
    out_valid = (state_q == StDone);
  end

  assign accept   = in_valid && in_ready;
  assign mul_last = (cnt_q == CntW'(WIDTH - 1));

  // FSM next-state process
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (command == CmdMul) ? StMul : StDone;
      end
      StMul: begin
        if (mul_last) state_d = StDone;
      end
      StDone: begin
        if (accept) begin
          state_d = (command == CmdMul) ? StMul : StDone;
        end else if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next-state
  always_comb begin
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (accept) begin
      if (command == CmdMul) begin
        mcand_d  = operandA;
        mplier_d = operandB;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        result_d  = alu_res;
        carry_d   = alu_carry;
        ovf_d     = alu_ovf;
        illegal_d = is_illegal(command);
        zero_d    = (alu_res == '0);
      end
    end else if (state_q == StMul) begin
      // Conditional add, then shift {carry, sum, mplier} right by one.
      acc_d    = {as_carry, as_sum[WIDTH-1:1]};
      mplier_d = {as_sum[0], mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q + CntW'(1);
      if (mul_last) begin
        result_d  = {as_sum[0], mplier_q[WIDTH-1:1]};
        carry_d   = |{as_carry, as_sum[WIDTH-1:1]};
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
        zero_d    = ({as_sum[0], mplier_q[WIDTH-1:1]} == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign result   = result_q;
  assign carryout = carry_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=4.
module tb_alu_seq;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] operandA = '0;
  logic [W-1:0] operandB = '0;
  logic [3:0]   command = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carryout, zero, overflow, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operandA (operandA),
    .operandB (operandB),
    .command  (command),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carryout (carryout),
    .zero     (zero),
    .overflow (overflow),
    .illegal  (illegal)
  );

  // Observed vector: {out_valid, result, carryout, zero, overflow, illegal}
  function automatic logic [8:0] obs();
    return {out_valid, result, carryout, zero, overflow, illegal};
  endfunction

  // Waits (bounded) for in_ready, presents one operation for one edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready got=%b want=1", in_ready);
    end
    operandA = a; operandB = b; command = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    n_cmp++;
    if (obs() !== 9'b0) begin
      n_bad++; $display("FAIL reset_outputs got=%b want=%b", obs(), 9'b0);
    end
    reset = 1'b0; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_addsub();
    logic [8:0] exp;
    send(4'b1011, 4'b1010, 4'd0);
    exp = {1'b1, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL add_ovf got=%b want=%b", obs(), exp);
    end
    retire();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL add_retire out_valid got=%b want=0", out_valid);
    end
    send(4'b0001, 4'b1111, 4'd0);
    exp = {1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL add_wrap_zero got=%b want=%b", obs(), exp);
    end
    retire();
    send(4'b0111, 4'b1010, 4'd1);
    exp = {1'b1, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL sub_ovf got=%b want=%b", obs(), exp);
    end
    retire();
    send(4'b0101, 4'b0011, 4'd1);
    exp = {1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL sub_noborrow got=%b want=%b", obs(), exp);
    end
    retire();
  endtask

  task automatic test_slt();
    logic [8:0] exp;
    send(4'b1010, 4'b1101, 4'd3);
    exp = {1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL slt_true got=%b want=%b", obs(), exp);
    end
    retire();
    send(4'b1100, 4'b1001, 4'd3);
    exp = {1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL slt_false got=%b want=%b", obs(), exp);
    end
    retire();
    // 7 - (-8) overflows; sign XOR overflow still yields "not less".
    send(4'b0111, 4'b1000, 4'd3);
    exp = {1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL slt_ovf got=%b want=%b", obs(), exp);
    end
    retire();
  endtask

  task automatic test_logic();
    logic [3:0] ta [5];
    logic [3:0] tb [5];
    logic [3:0] tc [5];
    logic [3:0] tr [5];
    logic [8:0] exp;
    ta = '{4'b0110, 4'b1100, 4'b1100, 4'b1100, 4'b0000};
    tb = '{4'b0011, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
    tc = '{4'd2,    4'd4,    4'd5,    4'd6,    4'd7};
    tr = '{4'b0101, 4'b1000, 4'b0111, 4'b0001, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb[i], tc[i]);
      exp = {1'b1, tr[i], 1'b0, (tr[i] == 4'b0000), 1'b0, 1'b0};
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++; $display("FAIL logic_op%0d got=%b want=%b", tc[i], obs(), exp);
      end
      retire();
    end
  endtask

  task automatic test_mul();
    logic [8:0] exp;
    send(4'b0011, 4'b0101, 4'd8);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b00) begin
        n_bad++; $display("FAIL mul_busy cyc%0d ready_valid got=%b want=00", i,
                          {in_ready, out_valid});
      end
      // Inputs wiggling during the sequence must be ignored.
      operandA = 4'($urandom); operandB = 4'($urandom); command = 4'd0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp = {1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL mul_3x5 got=%b want=%b", obs(), exp);
    end
    retire();
    send(4'b1111, 4'b1111, 4'd8);
    repeat (4) begin @(posedge clk); #1; end
    exp = {1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL mul_15x15 got=%b want=%b", obs(), exp);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    send(4'b0010, 4'b0011, 4'd0);
    exp = {1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      operandA = 4'($urandom); operandB = 4'($urandom); command = 4'd2;
      @(posedge clk); #1;
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++; $display("FAIL hold_cyc%0d got=%b want=%b", i, obs(), exp);
      end
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL hold_in_ready got=%b want=0", in_ready);
    end
    operandA = 4'b0101; operandB = 4'b1010; command = 4'd7;
    in_valid = 1'b1; out_ready = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_in_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    exp = {1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL b2b_or got=%b want=%b", obs(), exp);
    end
    retire();
  endtask

  task automatic test_reset_mul();
    logic [8:0] exp;
    logic       seen;
    send(4'b0011, 4'b0101, 4'd8);
    @(posedge clk); #1;
    reset = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rstmul_in_ready_hi got=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    n_cmp++;
    if ({in_ready, obs()} !== 10'b10_0000_0000) begin
      n_bad++; $display("FAIL rstmul_clear got=%b want=%b", {in_ready, obs()},
                        10'b10_0000_0000);
    end
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL rstmul_discard out_valid_seen got=%b want=0", seen);
    end
    send(4'b0110, 4'b0011, 4'b1100);
    exp = {1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL illegal_cmd got=%b want=%b", obs(), exp);
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_slt();
    test_logic();
    test_mul();
    test_back_to_back();
    test_reset_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
